// File: rtl/pcpi_pkg.sv
// Shared decode constants, FSM state and target encodings for the PCPI dispatcher.
// Pure definitions with no logic, latency or flow control of their own.
package pcpi_pkg;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP,
      COOL
   } state_t;

   typedef enum logic {
      TGT_MUL,
      TGT_DIV
   } tgt_t;

endpackage

// File: rtl/pcpi_insn_decode.sv
// Combinational M-extension decode: flags a hit and picks the multiply or divide unit.
// Zero latency; no flow control.
module pcpi_insn_decode
   import pcpi_pkg::*;
(
   input  logic [31:0] insn,
   output logic        hit,
   output tgt_t        target
);

   logic unused_insn_bits;

   assign hit    = (insn[6:0] == OPC_OP) && (insn[31:25] == F7_MULDIV);
   // funct3[2] separates MUL* (0) from DIV*/REM* (1)
   assign target = insn[14] ? TGT_DIV : TGT_MUL;

   assign unused_insn_bits = ^{insn[24:15], insn[13:7]};

endmodule

// File: rtl/pcpi_dispatch.sv
// Routes one PCPI request at a time to the mul or div unit; pcpi_ready pulses the cycle after sub ready is sampled.
// Core holds pcpi_valid until ready; dropping it aborts. Optional abort on timeout with PCPI_DISPATCH_TIMEOUT_EN.
module pcpi_dispatch
   import pcpi_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 80,
   parameter int CNT_W          = 7
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        pcpi_valid,
   input  logic [31:0] pcpi_insn,
   input  logic [31:0] pcpi_rs1,
   input  logic [31:0] pcpi_rs2,
   output logic        pcpi_wr,
   output logic [31:0] pcpi_rd,
   output logic        pcpi_wait,
   output logic        pcpi_ready,

   output logic        mul_valid,
   output logic [31:0] mul_insn,
   output logic [31:0] mul_rs1,
   output logic [31:0] mul_rs2,
   input  logic        mul_wr,
   input  logic [31:0] mul_rd,
   input  logic        mul_wait,
   input  logic        mul_ready,

   output logic        div_valid,
   output logic [31:0] div_insn,
   output logic [31:0] div_rs1,
   output logic [31:0] div_rs2,
   input  logic        div_wr,
   input  logic [31:0] div_rd,
   input  logic        div_wait,
   input  logic        div_ready,

   output logic        err_timeout
);

   state_t      state;
   tgt_t        tgt_q;
   tgt_t        dec_tgt;
   logic        dec_hit;
   logic [31:0] insn_q;
   logic [31:0] rs1_q;
   logic [31:0] rs2_q;

   logic        sub_ready;
   logic        sub_wr;
   logic [31:0] sub_rd;
   logic        unused_sub_wait;

   pcpi_insn_decode u_decode (
      .insn   (pcpi_insn),
      .hit    (dec_hit),
      .target (dec_tgt)
   );

   // Both units see the latched operands; only the selected one gets valid
   assign mul_insn = insn_q;
   assign mul_rs1  = rs1_q;
   assign mul_rs2  = rs2_q;
   assign div_insn = insn_q;
   assign div_rs1  = rs1_q;
   assign div_rs2  = rs2_q;

   always_comb begin
      sub_ready = mul_ready;
      sub_wr    = mul_wr;
      sub_rd    = mul_rd;
      if (tgt_q == TGT_DIV) begin
         sub_ready = div_ready;
         sub_wr    = div_wr;
         sub_rd    = div_rd;
      end
   end

   assign unused_sub_wait = mul_wait ^ div_wait;

`ifdef PCPI_DISPATCH_TIMEOUT_EN
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] busy_cnt;
   logic             err_q;
   assign err_timeout = err_q;
`else
   logic [CNT_W-1:0] unused_cnt_cfg;
   assign unused_cnt_cfg = CNT_W'(TIMEOUT_CYCLES);
   assign err_timeout    = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         tgt_q      <= TGT_MUL;
         insn_q     <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         mul_valid  <= 1'b0;
         div_valid  <= 1'b0;
         pcpi_wait  <= 1'b0;
         pcpi_ready <= 1'b0;
         pcpi_wr    <= 1'b0;
         pcpi_rd    <= '0;
`ifdef PCPI_DISPATCH_TIMEOUT_EN
         busy_cnt   <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         pcpi_ready <= 1'b0;
`ifdef PCPI_DISPATCH_TIMEOUT_EN
         err_q      <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (pcpi_valid && dec_hit) begin
                  insn_q    <= pcpi_insn;
                  rs1_q     <= pcpi_rs1;
                  rs2_q     <= pcpi_rs2;
                  tgt_q     <= dec_tgt;
                  mul_valid <= (dec_tgt == TGT_MUL);
                  div_valid <= (dec_tgt == TGT_DIV);
                  pcpi_wait <= 1'b1;
`ifdef PCPI_DISPATCH_TIMEOUT_EN
                  busy_cnt  <= '0;
`endif
                  state     <= BUSY;
               end
            end
            BUSY: begin
               // Core abort takes priority over a same-cycle unit response
               if (!pcpi_valid) begin
                  mul_valid <= 1'b0;
                  div_valid <= 1'b0;
                  pcpi_wait <= 1'b0;
                  state     <= COOL;
               end else if (sub_ready) begin
                  pcpi_wr    <= sub_wr;
                  pcpi_rd    <= sub_rd;
                  pcpi_ready <= 1'b1;
                  mul_valid  <= 1'b0;
                  div_valid  <= 1'b0;
                  pcpi_wait  <= 1'b0;
                  state      <= RESP;
               end
`ifdef PCPI_DISPATCH_TIMEOUT_EN
               else if (busy_cnt == CNT_LAST) begin
                  err_q     <= 1'b1;
                  mul_valid <= 1'b0;
                  div_valid <= 1'b0;
                  pcpi_wait <= 1'b0;
                  state     <= COOL;
               end else begin
                  busy_cnt <= busy_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               state <= COOL;
            end
            COOL: begin
               // Core may still hold valid for the insn just completed
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pcpi_dispatch.sv
// Self-checking bench for pcpi_dispatch: scoreboarded mul/div requests, non-M filtering,
// core abort, optional timeout and asynchronous reset mid-operation.
module tb_pcpi_dispatch;

`ifdef PCPI_DISPATCH_TIMEOUT_EN
   localparam int TB_TIMEOUT = 8;
   localparam int MUL_LAT    = 5;
   localparam int DIV_LAT    = 4;
`else
   localparam int TB_TIMEOUT = 80;
   localparam int MUL_LAT    = 34;
   localparam int DIV_LAT    = 10;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        pcpi_valid;
   logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
   logic        pcpi_wr, pcpi_wait, pcpi_ready;
   logic [31:0] pcpi_rd;
   logic        mul_valid, div_valid;
   logic [31:0] mul_insn, mul_rs1, mul_rs2, div_insn, div_rs1, div_rs2;
   logic        mul_wr, mul_wait, mul_ready, div_wr, div_wait, div_ready;
   logic [31:0] mul_rd, div_rd;
   logic        err_timeout;

   int checks   = 0;
   int failures = 0;

   logic [32:0] exp_q[$];
   bit saw_mul, saw_div, saw_wait, saw_err;

   always #5 clk = ~clk;

   pcpi_dispatch #(.TIMEOUT_CYCLES(TB_TIMEOUT), .CNT_W(7)) dut (
      .clk(clk), .reset(reset),
      .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
      .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
      .mul_valid(mul_valid), .mul_insn(mul_insn), .mul_rs1(mul_rs1), .mul_rs2(mul_rs2),
      .mul_wr(mul_wr), .mul_rd(mul_rd), .mul_wait(mul_wait), .mul_ready(mul_ready),
      .div_valid(div_valid), .div_insn(div_insn), .div_rs1(div_rs1), .div_rs2(div_rs2),
      .div_wr(div_wr), .div_rd(div_rd), .div_wait(div_wait), .div_ready(div_ready),
      .err_timeout(err_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic clear_flags();
      saw_mul  = 1'b0;
      saw_div  = 1'b0;
      saw_wait = 1'b0;
   endtask

   // Scoreboard pop on every completion pulse
   always @(negedge clk) begin
      logic [32:0] e;
      if (mul_valid) saw_mul = 1'b1;
      if (div_valid) saw_div = 1'b1;
      if (pcpi_wait) saw_wait = 1'b1;
      if (err_timeout) saw_err = 1'b1;
      if (mul_valid && div_valid) chk("both_valid", 1, 0);
      if (pcpi_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_ready", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_rd", pcpi_rd, e[31:0]);
            chk("sb_wr", {31'd0, pcpi_wr}, {31'd0, e[32]});
         end
      end
   end

   task automatic run_op(input string tag, input logic [31:0] insn, input logic [31:0] rs1,
                         input logic [31:0] rs2, input bit to_div, input int lat,
                         input logic [31:0] res);
      int n;
      exp_q.push_back({1'b1, res});
      @(negedge clk);
      pcpi_valid = 1'b1;
      pcpi_insn  = insn;
      pcpi_rs1   = rs1;
      pcpi_rs2   = rs2;
      n = 0;
      while (!(to_div ? div_valid : mul_valid) && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_accept_lat"}, n, 1);
      chk({tag, "_wait"}, {31'd0, pcpi_wait}, 1);
      chk({tag, "_fwd_insn"}, to_div ? div_insn : mul_insn, insn);
      chk({tag, "_fwd_rs1"}, to_div ? div_rs1 : mul_rs1, rs1);
      chk({tag, "_fwd_rs2"}, to_div ? div_rs2 : mul_rs2, rs2);
      repeat (lat) @(negedge clk);
      chk({tag, "_no_early_ready"}, {31'd0, pcpi_ready}, 0);
      if (to_div) begin
         div_ready = 1'b1; div_wr = 1'b1; div_rd = res;
      end else begin
         mul_ready = 1'b1; mul_wr = 1'b1; mul_rd = res;
      end
      @(negedge clk);
      mul_ready = 1'b0;
      div_ready = 1'b0;
      chk({tag, "_ready"}, {31'd0, pcpi_ready}, 1);
      chk({tag, "_wait_drop"}, {31'd0, pcpi_wait}, 0);
      chk({tag, "_valid_drop"}, {31'd0, (mul_valid | div_valid)}, 0);
      pcpi_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_ready_pulse"}, {31'd0, pcpi_ready}, 0);
      chk({tag, "_rd_hold"}, pcpi_rd, res);
      @(negedge clk);
   endtask

   initial begin
      int n;
      reset = 1'b1;
      pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
      mul_wr = 1'b0; mul_rd = '0; mul_wait = 1'b0; mul_ready = 1'b0;
      div_wr = 1'b0; div_rd = '0; div_wait = 1'b0; div_ready = 1'b0;
      saw_err = 1'b0;
      clear_flags();
      repeat (2) @(negedge clk);
      chk("rst_wait", {31'd0, pcpi_wait}, 0);
      chk("rst_ready", {31'd0, pcpi_ready}, 0);
      chk("rst_wr", {31'd0, pcpi_wr}, 0);
      chk("rst_rd", pcpi_rd, 0);
      chk("rst_valids", {30'd0, mul_valid, div_valid}, 0);
      chk("rst_ops", mul_insn | mul_rs1 | mul_rs2 | div_insn | div_rs1 | div_rs2, 0);
      chk("rst_err", {31'd0, err_timeout}, 0);
      reset = 1'b0;

      // MUL
      clear_flags();
      run_op("t1", 32'h02B50533, 32'd7, 32'd6, 1'b0, MUL_LAT, 32'd42);
      chk("t1_no_div", {31'd0, saw_div}, 0);

      // DIVU
      clear_flags();
      run_op("t2", 32'h02B55533, 32'd100, 32'd7, 1'b1, DIV_LAT, 32'd14);
      chk("t2_no_mul", {31'd0, saw_mul}, 0);

      // ADD is not ours
      @(negedge clk);
      clear_flags();
      pcpi_valid = 1'b1; pcpi_insn = 32'h00B50533; pcpi_rs1 = 32'd1; pcpi_rs2 = 32'd2;
      repeat (20) @(negedge clk);
      chk("t3_no_activity", {29'd0, saw_wait, saw_mul, saw_div}, 0);
      pcpi_valid = 1'b0;

      // Abort in the same cycle as mul_ready
      @(negedge clk);
      pcpi_valid = 1'b1; pcpi_insn = 32'h02B50533; pcpi_rs1 = 32'd3; pcpi_rs2 = 32'd5;
      n = 0;
      while (!mul_valid && n < 8) begin @(negedge clk); n++; end
      chk("t4_accept", {31'd0, mul_valid}, 1);
      repeat (4) @(negedge clk);
      pcpi_valid = 1'b0; mul_ready = 1'b1; mul_wr = 1'b1; mul_rd = 32'd99;
      @(negedge clk);
      mul_ready = 1'b0;
      chk("t4_mul_valid_drop", {31'd0, mul_valid}, 0);
      chk("t4_no_ready", {31'd0, pcpi_ready}, 0);
      chk("t4_wait_drop", {31'd0, pcpi_wait}, 0);
      @(negedge clk);
      chk("t4_rd_discard", pcpi_rd, 32'd14);
      @(negedge clk);

`ifdef PCPI_DISPATCH_TIMEOUT_EN
      @(negedge clk);
      pcpi_valid = 1'b1; pcpi_insn = 32'h02B50533; pcpi_rs1 = 32'd2; pcpi_rs2 = 32'd2;
      n = 0;
      while (!mul_valid && n < 8) begin @(negedge clk); n++; end
      chk("t5_accept", {31'd0, mul_valid}, 1);
      n = 0;
      while (!err_timeout && n < 20) begin @(negedge clk); n++; end
      chk("t5_timeout_cycle", n, TB_TIMEOUT);
      chk("t5_mul_valid_drop", {31'd0, mul_valid}, 0);
      chk("t5_no_ready", {31'd0, pcpi_ready}, 0);
      pcpi_valid = 1'b0;
      @(negedge clk);
      chk("t5_err_pulse", {31'd0, err_timeout}, 0);
      clear_flags();
      run_op("t5b", 32'h02B50533, 32'd4, 32'd5, 1'b0, 3, 32'd20);
`endif

      // Async reset mid-BUSY
      @(negedge clk);
      pcpi_valid = 1'b1; pcpi_insn = 32'h02B50533; pcpi_rs1 = 32'd9; pcpi_rs2 = 32'd9;
      n = 0;
      while (!mul_valid && n < 8) begin @(negedge clk); n++; end
      chk("t6_accept", {31'd0, mul_valid}, 1);
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("t6_rst_valid", {31'd0, mul_valid}, 0);
      chk("t6_rst_wait", {31'd0, pcpi_wait}, 0);
      chk("t6_rst_ops", mul_insn | mul_rs1 | mul_rs2, 0);
      chk("t6_rst_rd", pcpi_rd, 0);
      pcpi_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      clear_flags();
      run_op("t6b", 32'h02B50533, 32'd7, 32'd6, 1'b0, MUL_LAT, 32'd42);
      chk("t6b_no_div", {31'd0, saw_div}, 0);

      repeat (2) @(negedge clk);
      chk("sb_drain", exp_q.size(), 0);
`ifndef PCPI_DISPATCH_TIMEOUT_EN
      chk("err_tied0", {31'd0, saw_err}, 0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
